branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters. It predicts conditional branches in IF and is trained and checked in EX from the branch decision result, `BranchE`. It sits in the pipeline next to the EX-stage branch decision logic and consumes its output. Each cycle it provides a taken/target prediction for the fetch PC and, for the branch currently in EX, a mispredict flag plus the corrected next PC. The hazard unit and the next-PC mux use these outputs.

## Interface
- INDEX_BITS, 6, log2 of entry count (default 64 entries); index = PC[INDEX_BITS+1:2]
- TAG_BITS, 30-INDEX_BITS, derived, not overridable; tag = PC[31:INDEX_BITS+2]

- CPU_CLK  in  1  single clock, all state updates on rising edge
- CPU_RST  in  1  asynchronous, active-high reset
- PCF  in  32  fetch-stage PC
- PredTakenF  out  1  prediction for PCF: 1 = predicted taken
- PredTargetF  out  32  predicted target for PCF; 32'b0 when PredTakenF=0
- BranchTypeE  in  3  EX branch type; `NOBRANCH` (3'd0) means no conditional branch in EX
- StallE  in  1  EX stage held this cycle; blocks training
- PCE  in  32  PC of the instruction in EX
- BranchE  in  1  actual outcome from the EX decision logic
- BranchTargetE  in  32  computed branch target, PCE + imm
- PredTakenE  in  1  PredTakenF pipelined alongside the instruction into EX
- PredTargetE  in  32  PredTargetF pipelined alongside the instruction into EX
- MispredictE  out  1  1 = the prediction for the EX branch was wrong; flush IF/ID and redirect
- RedirectPCE  out  32  correct next PC for the EX branch

## Operation
- Storage: 2^INDEX_BITS entries, each holding valid (1b), tag (TAG_BITS), target (32b), and a counter (2b: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
- Lookup is combinational. A hit requires valid=1 and a stored tag equal to PCF[31:INDEX_BITS+2].
  - PredTakenF = hit & counter[1].
  - PredTargetF = target when PredTakenF=1, else 0.
- Check is combinational and active only when BranchTypeE != `NOBRANCH`.
  - MispredictE = (BranchE != PredTakenE) | (BranchE & PredTakenE & (BranchTargetE != PredTargetE)).
  - RedirectPCE = BranchE ? BranchTargetE : PCE + 4, with 32-bit wrap.
  - When BranchTypeE = `NOBRANCH`, MispredictE=0 and RedirectPCE=PCE+4.
- Training happens on a rising edge when BranchTypeE != `NOBRANCH` and StallE=0. The entry addressed by PCE is updated as follows:
  - Hit, taken: counter saturating-increments (11 stays 11); target <= BranchTargetE.
  - Hit, not taken: counter saturating-decrements (00 stays 00); target unchanged.
  - Miss, taken: allocate and overwrite any existing line. Set valid=1, tag from PCE, target=BranchTargetE, counter=10.
  - Miss, not taken: no change, no allocation.
- Aliasing PCs with the same index and a different tag evict each other. There is no replacement policy beyond overwrite.
- Unconditional jumps are not tracked. This block never sees them.

## Timing
- Lookup and check have zero-cycle latency; outputs are combinational from inputs and state.
- Training is visible to lookups from the cycle after the training edge.
- Same-cycle lookup and training of the same index: the lookup returns the pre-update contents. There is no write-to-read bypass.
- StallE=1 for N cycles with a branch held in EX: training happens exactly once, on the first edge with StallE=0. MispredictE remains asserted combinationally throughout the stall.
- Reset, asynchronous: all valid bits go to 0 and all counters to 01, immediately and regardless of the clock. Tags and targets need not be cleared.
  - During reset and after it, PredTakenF=0 and PredTargetF=0.
  - The reset values of MispredictE and RedirectPCE follow the combinational rules above from the EX inputs.
- Reset asserted mid-training: state is cleared and the pending update is lost.
- PCF and PCE are word-aligned; bits [1:0] are ignored.

## Test plan
- After reset, PCF=0x0000_0040 -> PredTakenF=0, PredTargetF=0. With BranchTypeE=`NOBRANCH`, PCE=0x3C -> MispredictE=0 and RedirectPCE=0x40.
- Allocation: one EX taken branch with PCE=0x40, BranchTargetE=0x80, PredTakenE=0 -> MispredictE=1 and RedirectPCE=0x80. On the next cycle, PCF=0x40 -> PredTakenF=1 and PredTargetF=0x80.
- Counter saturation: train PCE=0x40 taken 3 more times, then not-taken once -> counter reaches 11, then 10, and the entry still predicts taken. Two further not-taken updates -> counter reaches 00, PredTakenF=0, and the check at PCE=0x40 with PredTakenE=1, BranchE=0 gives MispredictE=1 and RedirectPCE=0x44.
- Alias eviction: with an entry for 0x40, train PCE=0x140 taken to target 0x200 -> PCF=0x40 misses (PredTakenF=0) and PCF=0x140 predicts taken to 0x200.
- Target mismatch and stall: the entry for 0x40 predicts 0x80; BranchE=1 with BranchTargetE=0x90 and StallE=1 for 3 cycles -> MispredictE=1 for all 3 cycles and the counter is unchanged. After release, one update stores target 0x90.
- Asynchronous reset between clock edges with valid entries present -> PredTakenF falls to 0 before the next CPU_CLK edge, and all lookups miss afterwards.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational IF lookup and EX check; training on the clock edge from the EX branch result.
module branch_target_buffer #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic [2:0]  BranchTypeE,
  input  logic        StallE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BranchTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE
);

  localparam int unsigned TAG_BITS    = 30 - INDEX_BITS;
  localparam int unsigned NUM_ENTRIES = 1 << INDEX_BITS;
  localparam logic [2:0]  NOBRANCH    = 3'd0;

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]             ctr_q    [NUM_ENTRIES];
  logic [1:0]             ctr_d    [NUM_ENTRIES];
  logic [TAG_BITS-1:0]    tag_q    [NUM_ENTRIES];
  logic [TAG_BITS-1:0]    tag_d    [NUM_ENTRIES];
  logic [31:0]            target_q [NUM_ENTRIES];
  logic [31:0]            target_d [NUM_ENTRIES];

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, hit_e;
  logic                  branch_e, train_e;
  logic                  unused_pc_lsbs;

  // Word-aligned PCs: the two low bits carry no information.
  assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

  assign idx_f    = PCF[INDEX_BITS+1:2];
  assign tag_f    = PCF[31:INDEX_BITS+2];
  assign idx_e    = PCE[INDEX_BITS+1:2];
  assign tag_e    = PCE[31:INDEX_BITS+2];
  assign hit_f    = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign branch_e = (BranchTypeE != NOBRANCH);
  assign train_e  = branch_e && !StallE;

  // Fetch-stage lookup
  always_comb begin
    PredTakenF  = hit_f & ctr_q[idx_f][1];
    PredTargetF = PredTakenF ? target_q[idx_f] : 32'd0;
  end

  // EX-stage check and redirect
  always_comb begin
    MispredictE = 1'b0;
    RedirectPCE = PCE + 32'd4;
    if (branch_e) begin
      MispredictE = (BranchE != PredTakenE) ||
                    (BranchE && PredTakenE && (BranchTargetE != PredTargetE));
      if (BranchE) RedirectPCE = BranchTargetE;
    end
  end

  // Training: saturating counter on hit, allocate only on a taken miss
  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (train_e) begin
      if (hit_e) begin
        if (BranchE) begin
          if (ctr_q[idx_e] != 2'b11) ctr_d[idx_e] = ctr_q[idx_e] + 2'd1;
          target_d[idx_e] = BranchTargetE;
        end else if (ctr_q[idx_e] != 2'b00) begin
          ctr_d[idx_e] = ctr_q[idx_e] - 2'd1;
        end
      end else if (BranchE) begin
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        target_d[idx_e] = BranchTargetE;
        ctr_d[idx_e]    = 2'b10;
      end
    end
  end

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tags and targets are only meaningful behind a valid bit, so they skip reset.
  always_ff @(posedge CPU_CLK) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized self-checking bench for branch_target_buffer against a behavioural table model,
// with directed scenarios pinning allocation, saturation, aliasing, stall and async reset.
module tb_branch_target_buffer;

  localparam int N = 64;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST = 1'b0;
  logic [31:0] PCF = '0;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic [2:0]  BranchTypeE = '0;
  logic        StallE = 1'b0;
  logic [31:0] PCE = '0;
  logic        BranchE = 1'b0;
  logic [31:0] BranchTargetE = '0;
  logic        PredTakenE = 1'b0;
  logic [31:0] PredTargetE = '0;
  logic        MispredictE;
  logic [31:0] RedirectPCE;

  branch_target_buffer dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST), .PCF(PCF),
    .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .BranchTypeE(BranchTypeE), .StallE(StallE), .PCE(PCE), .BranchE(BranchE),
    .BranchTargetE(BranchTargetE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(MispredictE), .RedirectPCE(RedirectPCE)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  int n_vec = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  // Behavioural model: one record per table slot, counter as a plain integer 0..3
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(N));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / 32'(4 * N);
  endfunction

  function automatic bit hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == tag_of(pc));
  endfunction

  function automatic bit pred_taken(input logic [31:0] pc);
    return hit(pc) && (m_ctr[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] pred_target(input logic [31:0] pc);
    return pred_taken(pc) ? m_tgt[slot(pc)] : 32'd0;
  endfunction

  always @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] <= 1'b0;
        m_ctr[i]   <= 1;
      end
    end else if (BranchTypeE != 3'd0 && !StallE) begin
      if (hit(PCE)) begin
        if (BranchE) begin
          m_ctr[slot(PCE)] <= (m_ctr[slot(PCE)] == 3) ? 3 : m_ctr[slot(PCE)] + 1;
          m_tgt[slot(PCE)] <= BranchTargetE;
        end else begin
          m_ctr[slot(PCE)] <= (m_ctr[slot(PCE)] == 0) ? 0 : m_ctr[slot(PCE)] - 1;
        end
      end else if (BranchE) begin
        m_valid[slot(PCE)] <= 1'b1;
        m_tag[slot(PCE)]   <= tag_of(PCE);
        m_tgt[slot(PCE)]   <= BranchTargetE;
        m_ctr[slot(PCE)]   <= 2;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  logic        e_mis;
  logic [31:0] e_red;

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge CPU_CLK) begin
    if (check_en) begin
      e_mis = 1'b0;
      e_red = PCE + 32'd4;
      if (BranchTypeE != 3'd0) begin
        e_mis = (BranchE != PredTakenE) ||
                (BranchE && PredTakenE && (BranchTargetE != PredTargetE));
        if (BranchE) e_red = BranchTargetE;
      end
      chk("model PredTakenF", 32'(PredTakenF), 32'(pred_taken(PCF)));
      chk("model PredTargetF", PredTargetF, pred_target(PCF));
      chk("model MispredictE", 32'(MispredictE), 32'(e_mis));
      chk("model RedirectPCE", RedirectPCE, e_red);
    end
  end

  task automatic cyc(input logic [31:0] pcf, input logic [2:0] bt, input logic st,
                     input logic [31:0] pce, input logic br, input logic [31:0] btgt,
                     input logic ptk, input logic [31:0] ptg);
    @(posedge CPU_CLK);
    #1;
    PCF = pcf; BranchTypeE = bt; StallE = st; PCE = pce; BranchE = br;
    BranchTargetE = btgt; PredTakenE = ptk; PredTargetE = ptg;
    @(negedge CPU_CLK);
  endtask

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] pc_r;
    #1 CPU_RST = 1'b1;
    #1 check_en = 1'b1;

    cyc(32'h40, 3'd0, 1'b0, 32'h3C, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("reset PredTakenF", 32'(PredTakenF), 32'd0);
    chk("reset PredTargetF", PredTargetF, 32'd0);
    chk("reset MispredictE", 32'(MispredictE), 32'd0);
    chk("reset RedirectPCE", RedirectPCE, 32'h40);
    CPU_RST = 1'b0;

    // Allocation on a taken miss
    cyc(32'h40, 3'd1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    chk("alloc MispredictE", 32'(MispredictE), 32'd1);
    chk("alloc RedirectPCE", RedirectPCE, 32'h80);
    chk("alloc no bypass", 32'(PredTakenF), 32'd0);
    cyc(32'h40, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("alloc PredTakenF", 32'(PredTakenF), 32'd1);
    chk("alloc PredTargetF", PredTargetF, 32'h80);

    // Saturation up, then down to strong not-taken
    repeat (3) cyc(32'h40, 3'd1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
    chk("sat correct pred", 32'(MispredictE), 32'd0);
    cyc(32'h40, 3'd1, 1'b0, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    cyc(32'h40, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("sat 10 still taken", 32'(PredTakenF), 32'd1);
    repeat (2) cyc(32'h40, 3'd1, 1'b0, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    cyc(32'h40, 3'd1, 1'b1, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    chk("sat 00 not taken", 32'(PredTakenF), 32'd0);
    chk("sat NT MispredictE", 32'(MispredictE), 32'd1);
    chk("sat NT RedirectPCE", RedirectPCE, 32'h44);

    // Alias eviction
    cyc(32'h40, 3'd1, 1'b0, 32'h140, 1'b1, 32'h200, 1'b0, 32'h0);
    cyc(32'h40, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("alias old misses", 32'(PredTakenF), 32'd0);
    cyc(32'h140, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("alias new taken", 32'(PredTakenF), 32'd1);
    chk("alias new target", PredTargetF, 32'h200);

    // Target mismatch held under stall
    cyc(32'h40, 3'd1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(32'h40, 3'd1, 1'b1, 32'h40, 1'b1, 32'h90, 1'b1, 32'h80);
      chk("stall MispredictE", 32'(MispredictE), 32'd1);
      chk("stall target held", PredTargetF, 32'h80);
    end
    cyc(32'h40, 3'd1, 1'b0, 32'h40, 1'b1, 32'h90, 1'b1, 32'h80);
    chk("release MispredictE", 32'(MispredictE), 32'd1);
    cyc(32'h40, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("release new target", PredTargetF, 32'h90);
    // Counter is 11 now; a stalled not-taken must train only once (11 -> 10)
    repeat (3) cyc(32'h40, 3'd1, 1'b1, 32'h40, 1'b0, 32'h90, 1'b1, 32'h90);
    cyc(32'h40, 3'd1, 1'b0, 32'h40, 1'b0, 32'h90, 1'b1, 32'h90);
    cyc(32'h40, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("stall trains once", 32'(PredTakenF), 32'd1);

    // Asynchronous reset between edges
    #2 CPU_RST = 1'b1;
    #1;
    chk("async PredTakenF", 32'(PredTakenF), 32'd0);
    chk("async PredTargetF", PredTargetF, 32'd0);
    @(posedge CPU_CLK);
    #1 CPU_RST = 1'b0;
    cyc(32'h40, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("post-reset 0x40 miss", 32'(PredTakenF), 32'd0);
    cyc(32'h140, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("post-reset 0x140 miss", 32'(PredTakenF), 32'd0);

    // Randomized traffic over a few aliasing slots, with occasional mid-cycle resets
    for (int n = 0; n < 3000; n++) begin
      @(posedge CPU_CLK);
      #1;
      CPU_RST       = ($urandom_range(0, 199) == 0);
      PCF           = rnd_pc();
      pc_r          = rnd_pc();
      PCE           = pc_r;
      BranchTypeE   = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      StallE        = ($urandom_range(0, 4) == 0);
      BranchE       = 1'($urandom_range(0, 1));
      BranchTargetE = ($urandom_range(0, 1) == 0) ? 32'h1000 + 32'($urandom_range(0, 3) * 4)
                                                  : $urandom;
      if ($urandom_range(0, 1) == 0) begin
        PredTakenE  = pred_taken(pc_r);
        PredTargetE = pred_target(pc_r);
      end else begin
        PredTakenE  = 1'($urandom_range(0, 1));
        PredTargetE = ($urandom_range(0, 1) == 0) ? BranchTargetE : $urandom;
      end
    end

    @(posedge CPU_CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
